// File: rtl/ddr_local_rsp_pkg.sv
// Shared types and constants for the DDR local-interface responder.
package ddr_local_rsp_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // Fibonacci LFSR for x^16+x^14+x^13+x^11+1: taps on bits 15, 13, 12, 10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    WR_BURST,
    RD_BURST
  } state_t;

endpackage

// File: rtl/ddr_local_rsp_ram.sv
// Single-port 2^MEM_AW x 32 RAM with per-byte write enables and a registered read port.
module ddr_local_rsp_ram
  import ddr_local_rsp_pkg::*;
#(
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic [MEM_AW-1:0] i_addr,
  input  logic [BE_W-1:0]   i_we,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**MEM_AW];

  // NOTE: storage and read register carry no reset; contents must survive a reset and
  // block-RAM macros offer no reset on the array.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/ddr_local_responder.sv
// Responder end of the DDR controller local port, backed by on-chip byte-enable RAM.
// Define DDR_LOCAL_RSP_STALL_INJECT_EN to add LFSR-driven ready stalls in IDLE/WR_BURST.
module ddr_local_responder
  import ddr_local_rsp_pkg::*;
#(
  parameter int ADDR_WIDTH   = 24,
  parameter int MEM_AW       = 12,
  parameter int SIZE_WIDTH   = 4,
  parameter int READ_LATENCY = 4,
  parameter int INIT_CYCLES  = 64
) (
  input  logic                  local_clk,
  input  logic                  local_reset_n,
  input  logic [ADDR_WIDTH-1:0] local_address,
  input  logic                  local_write_req,
  input  logic                  local_read_req,
  input  logic                  local_burstbegin,
  input  logic [DATA_W-1:0]     local_wdata,
  input  logic [BE_W-1:0]       local_be,
  input  logic [SIZE_WIDTH-1:0] local_size,
  output logic                  local_ready,
  output logic [DATA_W-1:0]     local_rdata,
  output logic                  local_rdata_valid,
  output logic                  local_init_done,
  output logic                  proto_err
);

  localparam int INIT_W = (INIT_CYCLES > 2) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

  state_t                              r_state, w_state_nxt;
  logic [INIT_W-1:0]                   r_init_cnt;
  logic [MEM_AW-1:0]                   r_addr, w_burst_addr, w_ram_addr;
  logic [SIZE_WIDTH-1:0]               r_beats, r_beat, w_beats_in;
  logic                                r_proto_err;
  logic                                w_last, w_stall, w_ready;
  logic                                w_issue, w_latch, w_beat_inc, w_set_err;
  logic [BE_W-1:0]                     w_ram_we;
  logic [DATA_W-1:0]                   w_ram_rdata;
  logic [READ_LATENCY-1:0]             r_vld;
  logic [READ_LATENCY-1:1][DATA_W-1:0] r_dat;
  logic                                w_unused;

  assign w_unused     = ^local_address[ADDR_WIDTH-1:MEM_AW];
  assign w_beats_in   = (local_size == '0) ? SIZE_WIDTH'(1) : local_size;
  assign w_burst_addr = r_addr + MEM_AW'(r_beat);
  assign w_last       = (r_beat == r_beats - SIZE_WIDTH'(1));

`ifdef DDR_LOCAL_RSP_STALL_INJECT_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge local_clk or negedge local_reset_n) begin
    if (!local_reset_n) r_lfsr <= LFSR_SEED;
    else                r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
  end

  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  // A stalled cycle drops ready, so every acceptance below is implicitly held.
  assign w_ready = ((r_state == IDLE) || (r_state == WR_BURST)) && !w_stall;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge local_clk or negedge local_reset_n) begin
    if (!local_reset_n) r_state <= INIT;
    else                r_state <= w_state_nxt;
  end

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ram_addr  = w_burst_addr;
    w_ram_we    = '0;
    w_issue     = 1'b0;
    w_latch     = 1'b0;
    w_beat_inc  = 1'b0;
    w_set_err   = 1'b0;
    unique case (r_state)
      INIT: begin
        if (r_init_cnt == INIT_LAST) w_state_nxt = IDLE;
      end
      IDLE: begin
        if (w_ready) begin
          if (local_write_req && local_burstbegin) begin
            w_ram_addr = local_address[MEM_AW-1:0];
            w_ram_we   = local_be;
            w_latch    = 1'b1;
            w_set_err  = local_read_req;
            if (w_beats_in != SIZE_WIDTH'(1)) w_state_nxt = WR_BURST;
          end else if (local_read_req && local_burstbegin) begin
            w_latch     = 1'b1;
            w_state_nxt = RD_BURST;
          end else if (local_write_req || local_read_req) begin
            w_set_err = 1'b1;
          end
        end
      end
      WR_BURST: begin
        if (w_ready) begin
          w_set_err = local_read_req || local_burstbegin;
          if (local_write_req) begin
            w_ram_we   = local_be;
            w_beat_inc = 1'b1;
            if (w_last) w_state_nxt = IDLE;
          end
        end
      end
      RD_BURST: begin
        w_issue    = 1'b1;
        w_beat_inc = 1'b1;
        if (w_last) w_state_nxt = IDLE;
      end
    endcase
  end

  // Beat 0 of a write lands in IDLE, so a write burst resumes at index 1.
  always_ff @(posedge local_clk or negedge local_reset_n) begin
    if (!local_reset_n) begin
      r_init_cnt  <= '0;
      r_addr      <= '0;
      r_beats     <= '0;
      r_beat      <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (r_state == INIT) r_init_cnt <= r_init_cnt + INIT_W'(1);
      if (w_latch) begin
        r_addr  <= local_address[MEM_AW-1:0];
        r_beats <= w_beats_in;
        r_beat  <= SIZE_WIDTH'(local_write_req);
      end else if (w_beat_inc) begin
        r_beat <= r_beat + SIZE_WIDTH'(1);
      end
      if (w_set_err) r_proto_err <= 1'b1;
    end
  end

  // RAM output register is stage 0; data only moves with its valid so rdata holds the last beat.
  always_ff @(posedge local_clk or negedge local_reset_n) begin
    if (!local_reset_n) begin
      r_vld <= '0;
      r_dat <= '0;
    end else begin
      r_vld <= {r_vld[READ_LATENCY-2:0], w_issue};
      if (r_vld[0]) r_dat[1] <= w_ram_rdata;
      for (int i = 2; i < READ_LATENCY; i++) begin
        if (r_vld[i-1]) r_dat[i] <= r_dat[i-1];
      end
    end
  end

  ddr_local_rsp_ram #(.MEM_AW(MEM_AW)) u_ram (
    .clk     (local_clk),
    .i_addr  (w_ram_addr),
    .i_we    (w_ram_we),
    .i_wdata (local_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign local_ready       = w_ready;
  assign local_init_done   = (r_state != INIT);
  assign local_rdata       = r_dat[READ_LATENCY-1];
  assign local_rdata_valid = r_vld[READ_LATENCY-1];
  assign proto_err         = r_proto_err;

endmodule

// File: tb/tb_ddr_local_responder.sv
// Randomized bench for ddr_local_responder against a word-array memory model with read timing.
module tb_ddr_local_responder;

  localparam int AW    = 24;
  localparam int MAW   = 12;
  localparam int SW    = 4;
  localparam int RL    = 4;
  localparam int INIT  = 64;
  localparam int DEPTH = 1 << MAW;

  logic          local_clk        = 1'b0;
  logic          local_reset_n    = 1'b1;
  logic [AW-1:0] local_address    = '0;
  logic          local_write_req  = 1'b0;
  logic          local_read_req   = 1'b0;
  logic          local_burstbegin = 1'b0;
  logic [31:0]   local_wdata      = '0;
  logic [3:0]    local_be         = '0;
  logic [SW-1:0] local_size       = '0;
  logic          local_ready;
  logic [31:0]   local_rdata;
  logic          local_rdata_valid;
  logic          local_init_done;
  logic          proto_err;

  ddr_local_responder #(
    .ADDR_WIDTH(AW), .MEM_AW(MAW), .SIZE_WIDTH(SW), .READ_LATENCY(RL), .INIT_CYCLES(INIT)
  ) dut (
    .local_clk         (local_clk),
    .local_reset_n     (local_reset_n),
    .local_address     (local_address),
    .local_write_req   (local_write_req),
    .local_read_req    (local_read_req),
    .local_burstbegin  (local_burstbegin),
    .local_wdata       (local_wdata),
    .local_be          (local_be),
    .local_size        (local_size),
    .local_ready       (local_ready),
    .local_rdata       (local_rdata),
    .local_rdata_valid (local_rdata_valid),
    .local_init_done   (local_init_done),
    .proto_err         (proto_err)
  );

  always #5 local_clk = ~local_clk;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  bit          mon_en   = 1'b0;
  logic [31:0] mem [DEPTH];
  exp_t        exp_q [$];
  exp_t        mon_e;
  logic [31:0] dq [$];
  logic [3:0]  bq [$];

  always @(posedge local_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Every valid beat must match the oldest outstanding expected word and its cycle.
  always @(negedge local_clk) begin
    if (mon_en && local_rdata_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_rvalid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rdata", local_rdata, mon_e.data);
        check("rvalid_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    local_write_req  = 1'b0;
    local_read_req   = 1'b0;
    local_burstbegin = 1'b0;
  endtask

  // Called at a negedge with a request driven; returns at the negedge after acceptance.
  task automatic wait_accept(output int acc_cyc);
    int n = 0;
    while (!local_ready && n < 100) begin
      @(negedge local_clk);
      n++;
    end
    if (!local_ready) check("accept_timeout", 32'd0, 32'd1);
    acc_cyc = cyc;
    @(negedge local_clk);
  endtask

  task automatic rand_fill(input int n, input bit full_be);
    dq.delete();
    bq.delete();
    for (int i = 0; i < n; i++) begin
      dq.push_back($urandom);
      bq.push_back(full_be ? 4'hF : 4'($urandom));
    end
  endtask

  task automatic write_burst(input logic [AW-1:0] addr, input int size, input int gap_at,
                             input int gap_len);
    int beats = (size == 0) ? 1 : size;
    logic [MAW-1:0] a = addr[MAW-1:0];
    int c;
    for (int k = 0; k < beats; k++) begin
      if (k == gap_at) begin
        idle_inputs();
        for (int g = 0; g < gap_len; g++) begin
          check("wr_wait_ready", 32'(local_ready), 32'd1);
          @(negedge local_clk);
        end
      end
      local_write_req  = 1'b1;
      local_burstbegin = (k == 0);
      local_address    = addr;
      local_size       = SW'(size);
      local_wdata      = dq[k];
      local_be         = bq[k];
      wait_accept(c);
      mem[a + MAW'(k)] = merge(mem[a + MAW'(k)], dq[k], bq[k]);
    end
    idle_inputs();
  endtask

  task automatic read_burst(input logic [AW-1:0] addr, input int size);
    int beats = (size == 0) ? 1 : size;
    logic [MAW-1:0] a = addr[MAW-1:0];
    int c;
    int n = 0;
    local_read_req   = 1'b1;
    local_burstbegin = 1'b1;
    local_address    = addr;
    local_size       = SW'(size);
    wait_accept(c);
    idle_inputs();
    for (int k = 0; k < beats; k++) exp_q.push_back('{mem[a + MAW'(k)], c + 1 + RL + k});
    while (!local_ready && n < 40) begin
      @(negedge local_clk);
      n++;
    end
    check("rd_ready_low_cycles", 32'(n), 32'(beats));
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge local_clk);
      n++;
    end
    check("rd_drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Asserts reset immediately, checks reset values, releases and times the init window.
  task automatic do_reset_init();
    int n = 0;
    bit early = 1'b0;
    mon_en = 1'b0;
    exp_q.delete();
    idle_inputs();
    local_reset_n = 1'b0;
    #1;
    check("rst_rvalid_now", 32'(local_rdata_valid), 32'd0);
    repeat (3) @(negedge local_clk);
    check("rst_ready", 32'(local_ready), 32'd0);
    check("rst_rdata", local_rdata, 32'd0);
    check("rst_init_done", 32'(local_init_done), 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    local_reset_n = 1'b1;
    mon_en = 1'b1;
    while (!local_init_done && n < 200) begin
      if (local_ready) early = 1'b1;
      @(negedge local_clk);
      n++;
    end
    check("init_cycles", 32'(n), 32'(INIT));
    check("init_ready_early", 32'(early), 32'd0);
    check("init_ready_with_done", 32'(local_ready), 32'd1);
    check("init_proto_err", 32'(proto_err), 32'd0);
  endtask

  initial begin
    int c;
    int beats;
    logic [AW-1:0] ra;

    @(negedge local_clk);
    do_reset_init();

    // Give every word a known value so any read can be predicted.
    for (int base = 0; base < DEPTH; base += 15) begin
      beats = (DEPTH - base < 15) ? DEPTH - base : 15;
      rand_fill(beats, 1'b1);
      write_burst(AW'(base), beats, -1, 0);
    end

    dq = {32'hDEADBEEF};
    bq = {4'b0101};
    write_burst(24'h000010, 1, -1, 0);
    read_burst(24'h000010, 1);

    rand_fill(4, 1'b1);
    write_burst(24'h000020, 4, 2, 2);
    read_burst(24'h000020, 4);

    read_burst(24'h000FFF, 3);

    for (int t = 0; t < 40; t++) begin
      ra = {12'($urandom), ($urandom_range(0, 3) == 0) ? 12'($urandom_range(4088, 4095))
                                                       : 12'($urandom_range(0, 127))};
      c = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        rand_fill((c == 0) ? 1 : c, 1'b0);
        write_burst(ra, c, $urandom_range(0, 15), $urandom_range(0, 3));
      end else begin
        read_burst(ra, c);
      end
    end
    check("proto_err_clean", 32'(proto_err), 32'd0);

    // Write without burstbegin in IDLE is dropped and flagged.
    local_write_req = 1'b1;
    local_address   = 24'h000010;
    local_wdata     = $urandom;
    local_be        = 4'hF;
    local_size      = SW'(1);
    @(negedge local_clk);
    idle_inputs();
    check("nobb_proto_err", 32'(proto_err), 32'd1);
    read_burst(24'h000010, 1);

    do_reset_init();

    // Write and read together: write wins, read dropped, error sticky.
    local_write_req  = 1'b1;
    local_read_req   = 1'b1;
    local_burstbegin = 1'b1;
    local_address    = 24'h000030;
    local_wdata      = $urandom;
    local_be         = 4'hF;
    local_size       = SW'(1);
    dq = {local_wdata};
    wait_accept(c);
    idle_inputs();
    mem[12'h030] = dq[0];
    check("conflict_proto_err", 32'(proto_err), 32'd1);
    repeat (12) @(negedge local_clk);
    check("conflict_proto_sticky", 32'(proto_err), 32'd1);
    read_burst(24'h000030, 1);

    // Reset lands while beat 2 of an 8-beat read is being issued.
    rand_fill(8, 1'b1);
    write_burst(24'h000100, 8, -1, 0);
    local_read_req   = 1'b1;
    local_burstbegin = 1'b1;
    local_address    = 24'h000100;
    local_size       = SW'(8);
    wait_accept(c);
    idle_inputs();
    repeat (2) @(negedge local_clk);
    do_reset_init();
    repeat (RL + 4) @(negedge local_clk);
    read_burst(24'h000100, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ddr_local_responder.md
Name: ddr_local_responder

Overview:
- Responder (slave) end of the DDR controller local interface, cycle-compatible with the ddr2_ctrl local port consumed by wb_ddr_ctrl.
- Backed by on-chip byte-enable RAM; emulates init delay, ready backpressure, burst writes and fixed-latency burst reads.
- Used as a drop-in memory for simulation and boards without DDR, and as the reference responder in wb_ddr_ctrl benches.

Parameters:
- ADDR_WIDTH, 24, local_address width in 32-bit words.
- MEM_AW, 12, log2 of RAM depth in words; address bits above MEM_AW-1 are ignored.
- SIZE_WIDTH, 4, local_size width.
- READ_LATENCY, 4, cycles from read-beat issue to its local_rdata_valid; legal range 2..8.
- INIT_CYCLES, 64, cycles after reset release before local_init_done.

Ports:
- local_clk  in  1  sole clock.
- local_reset_n  in  1  asynchronous, active-low reset.
- local_address  in  ADDR_WIDTH  burst start word address, sampled on the accepted burstbegin beat.
- local_write_req  in  1  write beat request.
- local_read_req  in  1  read burst request.
- local_burstbegin  in  1  first beat or command of a burst.
- local_wdata  in  32  write data.
- local_be  in  4  byte enables; bit n covers wdata[8n+7:8n].
- local_size  in  SIZE_WIDTH  burst length in beats; 0 is treated as 1.
- local_ready  out  1  request accepted when high.
- local_rdata  out  32  read data.
- local_rdata_valid  out  1  rdata qualifier.
- local_init_done  out  1  init complete, sticky until reset.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset values: local_ready=0, local_rdata=0, local_rdata_valid=0, local_init_done=0, proto_err=0. Reset clears FSM state, counters and the read pipeline. RAM contents are not cleared.
- Acceptance: a request is accepted on a cycle with local_ready=1 and a req input high.
- FSM states: INIT, IDLE, WR_BURST, RD_BURST.
- INIT:
  - Counter runs for INIT_CYCLES, then go to IDLE.
  - local_init_done and local_ready rise together on the first IDLE cycle.
- IDLE, accepted write with burstbegin:
  - Latch addr = local_address[MEM_AW-1:0] and beats = max(size,1).
  - Write beat 0 at addr, masked by be.
  - If beats > 1, go to WR_BURST; otherwise stay in IDLE.
- WR_BURST:
  - local_ready stays 1.
  - Each cycle with write_req=1 writes the next beat at addr+k, wrapping mod 2^MEM_AW.
  - write_req=0 is a wait state.
  - After the last beat, return to IDLE.
  - read_req or burstbegin in WR_BURST sets proto_err. The beat is still consumed as data; any read is ignored.
- IDLE, accepted read with burstbegin:
  - Latch addr and beats as for writes.
  - Go to RD_BURST; local_ready drops the next cycle.
- RD_BURST:
  - Issue one beat per cycle, starting the cycle after acceptance, at addr+k with wrap.
  - Beat k's local_rdata_valid is asserted exactly READ_LATENCY cycles after its issue cycle: one RAM-read register followed by READ_LATENCY-1 pipeline stages.
  - Valids are back-to-back; no gaps.
  - local_ready returns to 1 the cycle after the last issue.
  - A write accepted while read beats are still draining does not affect data already read from RAM.
- Request without burstbegin in IDLE: set proto_err, ignore the request.
- write_req and read_req both high in IDLE: the write is accepted, the read is dropped, proto_err is set.
- Reset mid-burst: an in-flight burst is aborted. No rdata_valid appears after reset; beats already written remain in RAM.
- Addresses and counters are unsigned; beat counter width is SIZE_WIDTH.

Optional Feature:
- Macro: DDR_LOCAL_RSP_STALL_INJECT_EN.
- Defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) forces local_ready=0 on any cycle where lfsr[1:0]==2'b00, in IDLE and WR_BURST.
  - The FSM and counters hold on forced cycles; requests are not accepted.
  - Read-beat issue is unaffected.
- Undefined: no LFSR logic; ready follows the FSM only.

Decomposition:
- Package ddr_local_rsp_pkg holds:
  - state enum {INIT, IDLE, WR_BURST, RD_BURST};
  - DATA_W=32 and BE_W=4 constants;
  - the LFSR seed and tap constants.
- Sub-module ddr_local_rsp_ram: single-port, 2^MEM_AW x 32, per-byte write enable, registered read.

Test Plan:
- Reset release -> local_ready=0 and local_init_done=0 for exactly 64 cycles, then both rise together; proto_err stays 0.
- Single write addr 0x10, data 0xDEADBEEF, be=4'b0101; then single read addr 0x10 -> rdata_valid 4 cycles after issue, with bytes 2 and 0 of rdata equal to 0xAD and 0xEF and bytes 3 and 1 holding the prior contents; local_ready low for exactly 1 cycle.
- Write burst size=4 at 0x20 with 2 wait cycles between beats 1 and 2; read burst size=4 at 0x20 -> 4 consecutive valids returning the written data in order.
- Read burst size=3 at 0xFFF (MEM_AW=12) -> beats come from words 0xFFF, 0x000, 0x001.
- write_req and read_req high together in IDLE with burstbegin -> write performed, no rdata_valid, proto_err=1 and sticky.
- Assert reset during beat 2 of an 8-beat read -> rdata_valid low within the reset cycle; after the 64-cycle init, the previously written data reads back intact.
